// File: rtl/alu_exec_unit.sv
// Single-issue ALU execute stage with a valid/ready handshake on both sides.
// Shifts can optionally iterate one bit per cycle to keep the datapath narrow.
module alu_exec_unit #(
  parameter int unsigned MULTICYCLE_SHIFT = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [4:0]  alu_ctrl,
  input  logic [31:0] src1,
  input  logic [31:0] src2,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] result,
  output logic        br_taken
);

  typedef enum logic [1:0] {IDLE, SHIFT, HOLD} state_t;
  typedef enum logic [1:0] {SH_SLL, SH_SRL, SH_SRA} shkind_t;

  state_t      state;
  shkind_t     shkind;
  logic [4:0]  cnt;
  logic [31:0] alu_res;
  logic        alu_br;
  logic        cond;
  logic        is_shift;
  logic        go_shift;
  logic        accept;
  logic [4:0]  amt;
  shkind_t     new_kind;

  assign amt = src2[4:0];

  always_comb begin
    alu_res  = '0;
    alu_br   = 1'b0;
    cond     = 1'b0;
    is_shift = 1'b0;
    new_kind = SH_SLL;
    case (alu_ctrl)
      5'd0: alu_res = src1 + src2;
      5'd1: alu_res = src1 - src2;
      5'd2: begin alu_res = src1 << amt; is_shift = 1'b1; new_kind = SH_SLL; end
      5'd3: begin alu_res = $unsigned($signed(src1) >>> amt); is_shift = 1'b1; new_kind = SH_SRA; end
      5'd4: begin alu_res = src1 >> amt; is_shift = 1'b1; new_kind = SH_SRL; end
      5'd5: alu_res = src1 ^ src2;
      5'd6: alu_res = src1 | src2;
      5'd7: alu_res = src1 & src2;
      5'd8: alu_res = {31'b0, $signed(src1) < $signed(src2)};
      5'd9: alu_res = {31'b0, src1 < src2};
      5'd10, 5'd11, 5'd12, 5'd13, 5'd14, 5'd15: begin
        case (alu_ctrl)
          5'd10:   cond = (src1 == src2);
          5'd11:   cond = (src1 != src2);
          5'd12:   cond = ($signed(src1) < $signed(src2));
          5'd13:   cond = ($signed(src1) >= $signed(src2));
          5'd14:   cond = (src1 < src2);
          default: cond = (src1 >= src2);
        endcase
        alu_res = {31'b0, cond};
        alu_br  = cond;
      end
      default: alu_res = '0;
    endcase
  end

  assign go_shift  = (MULTICYCLE_SHIFT != 0) && is_shift && (amt != 5'd0);
  assign in_ready  = !rst && ((state == IDLE) || ((state == HOLD) && out_ready));
  assign accept    = in_valid && in_ready;
  assign out_valid = (state == HOLD);

  // During SHIFT the result register doubles as the shift accumulator; it is
  // only observable as valid once the counter has run out.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      shkind   <= SH_SLL;
      cnt      <= '0;
      result   <= '0;
      br_taken <= 1'b0;
    end else if (accept) begin
      br_taken <= alu_br;
      if (go_shift) begin
        state  <= SHIFT;
        shkind <= new_kind;
        cnt    <= amt;
        result <= src1;
      end else begin
        state  <= HOLD;
        cnt    <= '0;
        result <= alu_res;
      end
    end else begin
      case (state)
        SHIFT: begin
          case (shkind)
            SH_SLL:  result <= {result[30:0], 1'b0};
            SH_SRL:  result <= {1'b0, result[31:1]};
            default: result <= {result[31], result[31:1]};
          endcase
          cnt <= cnt - 5'd1;
          if (cnt == 5'd1) state <= HOLD;
        end
        HOLD: if (out_ready) state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_exec_unit.sv
// Randomized scoreboard bench for alu_exec_unit: the driver pushes model
// predictions on accept, an independent monitor checks every presented output.
module tb_alu_exec_unit;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [4:0]  alu_ctrl = '0;
  logic [31:0] src1 = '0;
  logic [31:0] src2 = '0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [31:0] result;
  logic        br_taken;

  alu_exec_unit #(.MULTICYCLE_SHIFT(1)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .alu_ctrl(alu_ctrl), .src1(src1), .src2(src2), .out_valid(out_valid),
    .out_ready(out_ready), .result(result), .br_taken(br_taken)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] res;
    logic        br;
    int          lat;
    int          acc;
  } exp_t;

  exp_t sb[$];
  int   total = 0;
  int   bad = 0;
  int   cyc = 0;
  int   stall = 0;
  bit   rnd = 0;
  bit   done = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %h want %h (t=%0t)", name, act, req, $time);
    end
  endtask

  // Reference behaviour stated directly in arithmetic terms.
  function automatic exp_t model(input logic [4:0] c, input logic [31:0] a, input logic [31:0] b);
    exp_t e;
    int   sa;
    int   sa_i;
    int   sb_i;
    sa   = int'(b[4:0]);
    sa_i = int'(a);
    sb_i = int'(b);
    e.res = 0;
    e.br  = 0;
    e.lat = 0;
    e.acc = 0;
    case (c)
      0: e.res = a + b;
      1: e.res = a - b;
      2: e.res = a << sa;
      3: e.res = 32'(sa_i >>> sa);
      4: e.res = a >> sa;
      5: e.res = a ^ b;
      6: e.res = a | b;
      7: e.res = a & b;
      8: e.res = (sa_i < sb_i) ? 1 : 0;
      9: e.res = (a < b) ? 1 : 0;
      10: e.br = (a == b);
      11: e.br = (a != b);
      12: e.br = (sa_i < sb_i);
      13: e.br = (sa_i >= sb_i);
      14: e.br = (a < b);
      15: e.br = (a >= b);
      default: e.res = 0;
    endcase
    if (c >= 10 && c <= 15) e.res = {31'b0, e.br};
    if (c >= 2 && c <= 4) e.lat = sa;
    return e;
  endfunction

  task automatic set_or();
    if (stall > 0) begin
      out_ready = 1'b0;
      stall--;
    end else begin
      out_ready = rnd ? ($urandom_range(0, 3) != 0) : 1'b1;
    end
  endtask

  task automatic send(input logic [4:0] c, input logic [31:0] a, input logic [31:0] b);
    exp_t e;
    bit   ok = 0;
    int   n = 0;
    while (!ok && n < 200) begin
      @(posedge clk); #1;
      in_valid = 1'b1; alu_ctrl = c; src1 = a; src2 = b;
      set_or();
      @(negedge clk); #2;
      if (in_ready) begin
        e = model(c, a, b);
        e.acc = cyc + 1;
        sb.push_back(e);
        ok = 1;
      end
      n++;
    end
    if (!ok) chk("send_timeout", 32'(ok), 32'd1);
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk); #1;
      in_valid = 1'b0;
      alu_ctrl = 5'($urandom_range(0, 31));
      src1 = $urandom;
      src2 = $urandom;
      set_or();
    end
  endtask

  // Monitor: compares whatever the DUT presents against the scoreboard head.
  initial begin
    exp_t e;
    bit   seen = 0;
    forever begin
      @(negedge clk);
      if (rst) begin
        seen = 0;
      end else if (!done) begin
        if (out_valid) begin
          if (sb.size() == 0) begin
            chk("out_valid_unexpected", 32'(out_valid), 32'd0);
          end else begin
            e = sb[0];
            chk("result", result, e.res);
            chk("br_taken", 32'(br_taken), 32'(e.br));
            if (!seen) chk("latency", 32'(cyc - e.acc), 32'(e.lat));
            seen = 1;
            chk("in_ready_hold", 32'(in_ready), 32'(out_ready));
            if (out_ready) begin
              void'(sb.pop_front());
              seen = 0;
            end
          end
        end else if (sb.size() != 0) begin
          chk("in_ready_busy", 32'(in_ready), 32'd0);
        end else begin
          chk("in_ready_idle", 32'(in_ready), 32'd1);
        end
      end
    end
  end

  initial begin
    int w;
    #3;
    chk("rst_in_ready", 32'(in_ready), 32'd0);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_result", result, 32'd0);
    chk("rst_br", 32'(br_taken), 32'd0);
    @(posedge clk); @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk); #1;
    chk("post_rst_in_ready", 32'(in_ready), 32'd1);

    send(5'd0, 32'hFFFF_FFFF, 32'd1);
    send(5'd3, 32'h8000_0000, 32'h0000_0024);
    send(5'd12, 32'hFFFF_FFFF, 32'd1);
    send(5'd14, 32'hFFFF_FFFF, 32'd1);
    send(5'd1, 32'd5, 32'd7);
    stall = 3;
    send(5'd0, 32'd2, 32'd3);
    send(5'd25, 32'hDEAD_BEEF, 32'h1234_5678);
    send(5'd2, 32'h0000_0001, 32'h0000_0020);
    send(5'd4, 32'h8000_0000, 32'd31);
    send(5'd13, 32'h8000_0000, 32'h7FFF_FFFF);
    send(5'd16, 32'h1, 32'h1);
    idle(2);

    // Reset during an in-flight multi-cycle shift.
    send(5'd2, 32'h0000_0003, 32'd20);
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (5) @(posedge clk);
    #1 rst = 1'b1;
    #1;
    chk("midrst_out_valid", 32'(out_valid), 32'd0);
    chk("midrst_result", result, 32'd0);
    chk("midrst_in_ready", 32'(in_ready), 32'd0);
    sb.delete();
    @(posedge clk); @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk); #1;
    chk("midrst_release_ready", 32'(in_ready), 32'd1);
    chk("midrst_no_output", 32'(out_valid), 32'd0);

    rnd = 1;
    for (int i = 0; i < 250; i++) begin
      send(5'($urandom_range(0, 31)), $urandom, $urandom);
      if ($urandom_range(0, 2) == 0) idle($urandom_range(1, 3));
    end

    rnd = 0;
    stall = 0;
    w = 0;
    idle(1);
    while (sb.size() != 0 && w < 100) begin
      idle(1);
      w++;
    end
    chk("drain_empty", 32'(sb.size()), 32'd0);
    @(negedge clk);
    done = 1;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
